// File: rtl/imm_encoder.sv
// imm_encoder: two-stage RV32 I/S/B/U/J instruction packer with valid/ready; define IMM_ENCODER_RANGE_CHECK_EN to build immediate range checks
module imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  immSrc,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err,
  output logic [7:0]  err_count
);
  logic        r_s1_valid, r_s2_valid;
  logic [2:0]  r_s1_src, r_s1_funct3;
  logic [6:0]  r_s1_opcode, r_s1_funct7, r_s2_funct7;
  logic [4:0]  r_s1_rd, r_s1_rs1, r_s1_rs2;
  logic [31:0] r_s1_imm, r_instr, w_instr;
  logic        w_s1_adv, w_accept, w_unused;
  assign w_s1_adv  = !r_s2_valid || out_ready;
  assign in_ready  = !rst && (!r_s1_valid || w_s1_adv);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_s2_valid;
  assign instr     = r_instr;
  assign w_unused  = ^r_s2_funct7;
  always_comb begin
    w_instr = r_s1_src == 3'd0 ? {r_s1_imm[11:0], r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode}
            : r_s1_src == 3'd1 ? {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_imm[4:0], r_s1_opcode}
            : r_s1_src == 3'd2 ? {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_imm[4:1], r_s1_imm[11], r_s1_opcode}
            : r_s1_src == 3'd3 ? {r_s1_imm[31:12], r_s1_rd, r_s1_opcode}
            : r_s1_src == 3'd4 ? {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12], r_s1_rd, r_s1_opcode}
            : 32'b0;
  end
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_src    <= immSrc;
      r_s1_opcode <= opcode;
      r_s1_rd     <= rd;
      r_s1_funct3 <= funct3;
      r_s1_rs1    <= rs1;
      r_s1_rs2    <= rs2;
      r_s1_funct7 <= funct7;
      r_s1_imm    <= imm;
    end
    if (w_s1_adv && r_s1_valid)
      r_s2_funct7 <= r_s1_funct7;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_instr    <= 32'b0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_s1_adv) r_s2_valid <= r_s1_valid;
      if (w_s1_adv && r_s1_valid) r_instr <= w_instr;
    end
  end
`ifdef IMM_ENCODER_RANGE_CHECK_EN
  logic       w_err, w_eq11, w_eq12, w_eq20, r_s1_err, r_err;
  logic [7:0] r_err_count;
  assign w_eq11 = &imm[31:11] || ~|imm[31:11];
  assign w_eq12 = &imm[31:12] || ~|imm[31:12];
  assign w_eq20 = &imm[31:20] || ~|imm[31:20];
  always_comb begin
    w_err = immSrc == 3'd0 || immSrc == 3'd1 ? !w_eq11
          : immSrc == 3'd2 ? imm[0] || !w_eq12
          : immSrc == 3'd3 ? |imm[11:0]
          : immSrc == 3'd4 ? imm[0] || !w_eq20
          : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (w_accept) r_s1_err <= w_err;
    if (rst) begin
      r_err       <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      if (w_s1_adv && r_s1_valid) r_err <= r_s1_err;
      if (r_s2_valid && out_ready && r_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end
  end
  assign err       = r_err;
  assign err_count = r_err_count;
`else
  assign err       = 1'b0;
  assign err_count = 8'd0;
`endif
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: table-driven and sequence checks for imm_encoder
module tb_imm_encoder;
`ifdef IMM_ENCODER_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef struct {
    logic [2:0]  src;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, err;
  logic [2:0]  immSrc = '0, funct3 = '0;
  logic [6:0]  opcode = '0, funct7 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0, instr;
  logic [7:0]  err_count;
  int          tests = 0, fails = 0, err_model = 0;
  vec_t        v[14];
  imm_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .immSrc(immSrc), .opcode(opcode), .rd(rd), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .err(err), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic drive(input vec_t x);
    immSrc = x.src; opcode = x.op; rd = x.rd; funct3 = x.f3;
    rs1 = x.rs1; rs2 = x.rs2; funct7 = x.f7; imm = x.imm;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int sent, rcv, gap, acc;
    bit started, seen;
    v[0]  = '{3'd0, 7'h13, 5'd1,  3'd0, 5'd0,  5'd0, 7'h00, 32'h00000005, 32'h00500093, 1'b0};
    v[1]  = '{3'd1, 7'h23, 5'd31, 3'd2, 5'd1,  5'd2, 7'h7F, 32'h00000008, 32'h0020A423, 1'b0};
    v[2]  = '{3'd2, 7'h63, 5'd0,  3'd0, 5'd0,  5'd0, 7'h00, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
    v[3]  = '{3'd3, 7'h37, 5'd5,  3'd0, 5'd0,  5'd0, 7'h55, 32'h12345000, 32'h123452B7, 1'b0};
    v[4]  = '{3'd4, 7'h6F, 5'd1,  3'd0, 5'd0,  5'd0, 7'h00, 32'h00000800, 32'h001000EF, 1'b0};
    v[5]  = '{3'd0, 7'h13, 5'd1,  3'd0, 5'd0,  5'd0, 7'h00, 32'h00000800, 32'h80000093, 1'b1};
    v[6]  = '{3'd2, 7'h63, 5'd0,  3'd0, 5'd0,  5'd0, 7'h00, 32'h00000003, 32'h00000163, 1'b1};
    v[7]  = '{3'd7, 7'h33, 5'd1,  3'd0, 5'd2,  5'd3, 7'h00, 32'h00000005, 32'h00000000, 1'b1};
    v[8]  = '{3'd1, 7'h23, 5'd0,  3'd2, 5'd0,  5'd0, 7'h00, 32'hFFFFFFFF, 32'hFE002FA3, 1'b0};
    v[9]  = '{3'd3, 7'h37, 5'd0,  3'd0, 5'd0,  5'd0, 7'h00, 32'h12345001, 32'h12345037, 1'b1};
    v[10] = '{3'd4, 7'h6F, 5'd0,  3'd0, 5'd0,  5'd0, 7'h00, 32'hFFFFFFFE, 32'hFFFFF06F, 1'b0};
    v[11] = '{3'd4, 7'h6F, 5'd0,  3'd0, 5'd0,  5'd0, 7'h00, 32'h00100000, 32'h8000006F, 1'b1};
    v[12] = '{3'd5, 7'h13, 5'd1,  3'd0, 5'd0,  5'd0, 7'h00, 32'h00000005, 32'h00000000, 1'b1};
    v[13] = '{3'd0, 7'h13, 5'd1,  3'd0, 5'd0,  5'd0, 7'h00, 32'hFFFFF800, 32'h80000093, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);
    rst = 1'b0;
    #1 chk("rst_release_in_ready", in_ready, 1);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(v[i]);
      in_valid = 1'b1;
      #1 chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk($sformatf("v%0d_lat1_valid", i), out_valid, 0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_lat2_valid", i), out_valid, 1);
      chk($sformatf("v%0d_instr", i), instr, v[i].exp_instr);
      chk($sformatf("v%0d_err", i), err, v[i].exp_err & CHK);
      if (v[i].exp_err & CHK) err_model++;
    end
    @(negedge clk);
    #1 chk("table_err_count", err_count, err_model);
    out_ready = 1'b0; sent = 0; rcv = 0; gap = 0; started = 0;
    for (int c = 0; c < 30 && rcv < 4; c++) begin
      @(negedge clk);
      out_ready = c >= 3;
      in_valid = sent < 4;
      if (sent < 4) drive(v[sent]);
      #1;
      if (c == 2) chk("bp_in_ready_drop", in_ready, 0);
      if (started && !out_valid) gap++;
      if (out_valid) started = 1;
      if (out_valid && out_ready) begin
        chk($sformatf("bp_instr%0d", rcv), instr, v[rcv].exp_instr);
        chk($sformatf("bp_err%0d", rcv), err, 0);
        rcv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    chk("bp_received", rcv, 4);
    chk("bp_bubbles", gap, 0);
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(v[5 + i]);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1 chk("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_instr", instr, 0);
    chk("midrst_err", err, 0);
    chk("midrst_err_count", err_count, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1 chk("midrst_release_in_ready", in_ready, 1);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      #1 if (out_valid) seen = 1;
    end
    chk("midrst_no_output", seen, 0);
    drive(v[7]);
    in_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 400 && acc < 300; c++) begin
      @(negedge clk);
      #1 if (in_ready) acc++;
    end
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("sat_accepted", acc, 300);
    chk("sat_err_count", err_count, CHK ? 255 : 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
